multicycle_proc_core: RTL and testbench
=======================================

// Module: multicycle_proc_core
// PURPOSE
//   Parametrised multi-cycle register-file processor core for the board-level top.
//   Decodes one instruction word taken from IN_DATA_BUS and runs it over timesteps T0..T3.
//   Each timestep advances on a one-cycle STEP pulse. STEP comes from the debounced,
//   edge-detected key. Exposes the timestep (HEX), a Done pulse, flags, and a register peek.
// PARAMETERS
//   DW     10  data/bus width in bits; must be >= INSTR_W
//   NREGS  4   register count; power of 2, >= 2; RB = $clog2(NREGS) (localparam)
//   INSTR_W = 3 + 2*RB (localparam); instr = IN_DATA_BUS[INSTR_W-1:0]; upper bits ignored
// PORTS
//   CLK          in   1      single system clock; all state changes on rising edge
//   Reset        in   1      synchronous, active-high reset
//   STEP         in   1      one-cycle advance pulse; every cycle it is high counts as one step
//   IN_DATA_BUS  in   DW     instruction word (at T0) or LOAD data (at T1)
//   PKb          in   1      peek enable, active-high at this boundary
//   PEEK_SEL     in   RB     register index to peek
//   OUT_DATA_BUS out  DW     PKb ? R[PEEK_SEL] : LAST (last value written to any register)
//   TSTEP        out  2      current timestep 0..3
//   Done         out  1      one-cycle pulse; instruction retired
//   C_FLAG       out  1      carry (ADD) / borrow (SUB) of the last ALU instruction
//   Z_FLAG       out  1      result == 0 for the last instruction that wrote a register
// BEHAVIOUR
//   Reset: R[*]=0, IR=0, A=0, G=0, LAST=0, TSTEP=0, Done=0, C_FLAG=0, Z_FLAG=0.
//   Reset takes priority over STEP in the same cycle.
//   Mid-instruction reset aborts the instruction with no register write.
//   Instr fields: op=[INSTR_W-1 -: 3], Rx=[2*RB-1 -: RB], Ry=[RB-1:0].
//   Opcodes: 000 LOAD Rx<-data
//            001 COPY Rx<-Ry
//            010 ADD  Rx<-Rx+Ry
//            011 SUB  Rx<-Rx-Ry
//            100 INV  Rx<-~Ry
//            101 AND
//            110 OR
//            111 XOR
//   FSM (TSTEP): nothing changes without STEP. Each transition below happens on a STEP cycle.
//     T0: IR<-IN_DATA_BUS[INSTR_W-1:0]; go to T1.
//     T1, LOAD: Rx<-IN_DATA_BUS. T1, COPY/INV: Rx<-f(R[Ry]). Either: retire, go to T0.
//     T1, two-operand ops: A<-R[Rx]; go to T2.
//     T2: G<-A op R[Ry]; C_FLAG updated (ADD/SUB only, else unchanged); go to T3.
//     T3: Rx<-G; retire; go to T0.
//   Retire: LAST<-written value and Z_FLAG<-(value==0), on the same edge as the write.
//     Done=1 for exactly the cycle following that edge.
//   Arithmetic: modulo 2^DW.
//     ADD: C = carry out of bit DW-1.
//     SUB: A + ~R[Ry] + 1; C = 1 when A < R[Ry] unsigned (borrow).
//   Rx==Ry is legal: ADD doubles; SUB gives 0 with C=0; XOR gives 0.
//   Operands are read at their T1/T2 edge. Rx is rewritten only at T3.
//   OUT_DATA_BUS is combinational from registers. A peek on Rx during T1..T3 shows the old
//     value until the write edge, then the new value in the next cycle.
//   Latency: LOAD/COPY/INV take 2 STEPs; ADD/SUB/AND/OR/XOR take 4 STEPs.
//     Done is 1 cycle after the final STEP.
// TESTING
//   1 Reset; STEP w/ bus=0x000 (LOAD R0); STEP w/ bus=0x155
//     -> R0=0x155, Done pulse 1 cyc, TSTEP=0, OUT=0x155 (PKb=0).
//   2 R0=0x3FF, R1=0x001; ADD R1,R0 (0x24), 4 STEPs -> R1=0x000, C=1, Z=1, Done after 4th STEP.
//   3 R2=5, R3=7; SUB R2,R3 (0x3B) -> R2=0x3FE, C=1, Z=0. Then SUB R2,R2 -> R2=0, C=0, Z=1.
//   4 PKb=1, PEEK_SEL=1 during an ADD R1 (R1=0x010, R0=0x001): OUT=0x010 through T3.
//     OUT=0x011 on the cycle after the final edge. No STEP for 20 cycles -> TSTEP and regs frozen.
//   5 Reset asserted together with STEP at T2 of an ADD -> next cycle TSTEP=0, all R=0,
//     Done=0, flags 0, no write.
//   6 DW=16, NREGS=8 (INSTR_W=9): LOAD R7=0xBEEF; INV R6,R7 -> R6=0x4110;
//     XOR R7,R7 -> R7=0, Z=1; STEP held high 4 cycles -> 4 timesteps advance.

Source files
------------

// File: rtl/multicycle_proc_core.sv
// -----------------------------------------------------------------------------
// multicycle_proc_core
//   Multi-cycle register-file processor core. An instruction word is latched
//   from IN_DATA_BUS at timestep T0 and executed over T1..T3. The core advances
//   one timestep per cycle that STEP is high. Nothing changes while STEP is low.
//
// Ports
//   CLK           system clock, all state changes on the rising edge
//   Reset         synchronous active-high reset; has priority over STEP
//   STEP          advance pulse; every high cycle counts as one step
//   IN_DATA_BUS   instruction word (T0) or LOAD data (T1)
//   PKb           peek enable: OUT_DATA_BUS shows R[PEEK_SEL] instead of LAST
//   PEEK_SEL      register index to peek
//   OUT_DATA_BUS  PKb ? R[PEEK_SEL] : last value written to any register
//   TSTEP         current timestep 0..3
//   Done          one-cycle pulse in the cycle after an instruction retires
//   C_FLAG        carry (ADD) / borrow (SUB) of the last ADD/SUB
//   Z_FLAG        last written register value was zero
// -----------------------------------------------------------------------------
module multicycle_proc_core #(
  parameter int DW    = 10,
  parameter int NREGS = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     STEP,
  input  logic [DW-1:0]            IN_DATA_BUS,
  input  logic                     PKb,
  input  logic [$clog2(NREGS)-1:0] PEEK_SEL,
  output logic [DW-1:0]            OUT_DATA_BUS,
  output logic [1:0]               TSTEP,
  output logic                     Done,
  output logic                     C_FLAG,
  output logic                     Z_FLAG
);

  localparam int RB      = $clog2(NREGS);
  localparam int INSTR_W = 3 + 2 * RB;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_COPY = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_INV  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  tstep_e               state_q, state_d;
  logic [DW-1:0]        regs_q [NREGS];
  logic [INSTR_W-1:0]   ir_q;
  logic [DW-1:0]        a_q, g_q, last_q;
  logic                 done_q, c_q, z_q;

  logic [2:0]           op;
  logic [RB-1:0]        rx, ry;
  logic [DW-1:0]        rx_val, ry_val;
  logic                 single_step;

  // control strobes from the output process
  logic                 ir_load, a_load, g_load, wr_en;
  logic [DW-1:0]        wr_data;

  // ALU
  logic [DW:0]          sum_ext, diff_ext;
  logic [DW-1:0]        alu_res;
  logic                 alu_c;

  assign op     = ir_q[INSTR_W-1 -: 3];
  assign rx     = ir_q[2*RB-1 -: RB];
  assign ry     = ir_q[RB-1:0];
  assign rx_val = regs_q[rx];
  assign ry_val = regs_q[ry];

  // LOAD/COPY/INV finish at T1; everything else needs the A/G path.
  assign single_step = (op == OP_LOAD) || (op == OP_COPY) || (op == OP_INV);

  assign sum_ext  = {1'b0, a_q} + {1'b0, ry_val};
  // Two's-complement subtract; the carry out is the inverse of the borrow.
  assign diff_ext = {1'b0, a_q} + {1'b0, ~ry_val} + (DW+1)'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = c_q;  // flag holds for logic ops
    case (op)
      OP_ADD: {alu_c, alu_res} = sum_ext;
      OP_SUB: begin
        alu_res = diff_ext[DW-1:0];
        alu_c   = ~diff_ext[DW];
      end
      OP_AND:  alu_res = a_q & ry_val;
      OP_OR:   alu_res = a_q | ry_val;
      OP_XOR:  alu_res = a_q ^ ry_val;
      default: alu_res = '0;
    endcase
  end

  // ---------------- FSM: state register --------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ------------------------------------------
  always_comb begin
    state_d = state_q;
    if (STEP) begin
      case (state_q)
        T0: state_d = T1;
        T1: state_d = single_step ? T0 : T2;
        T2: state_d = T3;
        T3: state_d = T0;
        default: state_d = T0;
      endcase
    end
  end

  // ---------------- FSM: outputs (datapath strobes) --------------------------
  always_comb begin
    ir_load = 1'b0;
    a_load  = 1'b0;
    g_load  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    if (STEP) begin
      case (state_q)
        T0: ir_load = 1'b1;
        T1: begin
          case (op)
            OP_LOAD: begin wr_en = 1'b1; wr_data = IN_DATA_BUS; end
            OP_COPY: begin wr_en = 1'b1; wr_data = ry_val;      end
            OP_INV:  begin wr_en = 1'b1; wr_data = ~ry_val;     end
            default: a_load = 1'b1;
          endcase
        end
        T2: g_load = 1'b1;
        T3: begin wr_en = 1'b1; wr_data = g_q; end
        default: ;
      endcase
    end
  end

  // ---------------- datapath registers ---------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      last_q <= '0;
      done_q <= 1'b0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      if (ir_load) ir_q <= IN_DATA_BUS[INSTR_W-1:0];
      if (a_load)  a_q  <= rx_val;
      if (g_load) begin
        g_q <= alu_res;
        c_q <= alu_c;
      end
      // Every register write is a retire.
      if (wr_en) begin
        regs_q[rx] <= wr_data;
        last_q     <= wr_data;
        z_q        <= (wr_data == '0);
      end
      done_q <= wr_en;
    end
  end

  assign OUT_DATA_BUS = PKb ? regs_q[PEEK_SEL] : last_q;
  assign TSTEP        = state_q;
  assign Done         = done_q;
  assign C_FLAG       = c_q;
  assign Z_FLAG       = z_q;

endmodule

// File: tb/tb_multicycle_proc_core.sv
module tb_multicycle_proc_core;

  // ---------------- clock and DUT (DW=10, NREGS=4) ---------------------------
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset, STEP, PKb;
  logic [9:0] IN_DATA_BUS, OUT_DATA_BUS;
  logic [1:0] PEEK_SEL, TSTEP;
  logic       Done, C_FLAG, Z_FLAG;

  multicycle_proc_core #(.DW(10), .NREGS(4)) u_dut (
    .CLK(clk), .Reset(Reset), .STEP(STEP), .IN_DATA_BUS(IN_DATA_BUS),
    .PKb(PKb), .PEEK_SEL(PEEK_SEL), .OUT_DATA_BUS(OUT_DATA_BUS),
    .TSTEP(TSTEP), .Done(Done), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG)
  );

  // ---------------- second DUT (DW=16, NREGS=8) ------------------------------
  logic        step16, pk16;
  logic [15:0] bus16, out16;
  logic [2:0]  sel16;
  logic [1:0]  ts16;
  logic        done16, c16, z16;

  multicycle_proc_core #(.DW(16), .NREGS(8)) u_dut16 (
    .CLK(clk), .Reset(Reset), .STEP(step16), .IN_DATA_BUS(bus16),
    .PKb(pk16), .PEEK_SEL(sel16), .OUT_DATA_BUS(out16),
    .TSTEP(ts16), .Done(done16), .C_FLAG(c16), .Z_FLAG(z16)
  );

  // ---------------- bookkeeping ----------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ------------------------------------------
  int unsigned mr [4];
  int unsigned mlast;
  bit          mc, mz;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mr[i] = 0;
    mlast = 0; mc = 0; mz = 0;
  endtask

  // Executes one instruction on the architectural state using plain integers.
  task automatic model_exec(input logic [9:0] instr, input logic [9:0] data,
                            output logic [9:0] ev, output logic ec, output logic ez);
    int unsigned op, rx, ry, a, b, v, s;
    op = instr[6:4]; rx = instr[3:2]; ry = instr[1:0];
    a = mr[rx]; b = mr[ry]; v = 0;
    case (op)
      0: v = data;
      1: v = b;
      2: begin s = a + b; v = s % 1024; mc = (s >= 1024); end
      3: begin mc = (a < b); v = (a + 1024 - b) % 1024; end
      4: v = 1023 - b;
      5: v = a & b;
      6: v = a | b;
      default: v = a ^ b;
    endcase
    mr[rx] = v; mlast = v; mz = (v == 0);
    ev = v[9:0]; ec = mc; ez = mz;
  endtask

  // ---------------- stimulus helpers -----------------------------------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic step_bus(input logic [9:0] bus);
    STEP = 1'b1; IN_DATA_BUS = bus;
    @(posedge clk); #1;
    STEP = 1'b0;
  endtask

  // Runs one instruction with random gaps between steps and checks retirement.
  task automatic run_instr(input logic [9:0] instr, input logic [9:0] data,
                           input logic [9:0] ev, input logic ec, input logic ez);
    logic [2:0] op;
    int         n;
    op = instr[6:4];
    n  = (op == 3'd0 || op == 3'd1 || op == 3'd4) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      if (k > 0) idle($urandom_range(0, 2));
      chk("tstep_before_step", {30'd0, TSTEP}, k);
      if (k > 0) chk("done_mid_instr", {31'd0, Done}, 0);
      step_bus(k == 0 ? instr : (k == 1 ? data : 10'($urandom)));
    end
    chk("done_pulse", {31'd0, Done}, 1);
    chk("tstep_after_retire", {30'd0, TSTEP}, 0);
    chk("out_last", {22'd0, OUT_DATA_BUS}, {22'd0, ev});
    chk("c_flag", {31'd0, C_FLAG}, {31'd0, ec});
    chk("z_flag", {31'd0, Z_FLAG}, {31'd0, ez});
    PKb = 1'b1; PEEK_SEL = instr[3:2]; #1;
    chk("peek_rx", {22'd0, OUT_DATA_BUS}, {22'd0, ev});
    PKb = 1'b0;
    idle(1);
    chk("done_clear", {31'd0, Done}, 0);
    $display("instr 0x%03h data 0x%03h -> R%0d=0x%03h C=%0d Z=%0d",
             instr, data, instr[3:2], ev, ec, ez);
  endtask

  task automatic model_run(input logic [9:0] instr, input logic [9:0] data);
    logic [9:0] ev;
    logic       ec, ez;
    model_exec(instr, data, ev, ec, ez);
    run_instr(instr, data, ev, ec, ez);
  endtask

  task automatic step16_bus(input logic [15:0] bus);
    step16 = 1'b1; bus16 = bus;
    @(posedge clk); #1;
    step16 = 1'b0;
  endtask

  // ---------------- directed vector table ------------------------------------
  typedef struct {
    logic [9:0] instr;
    logic [9:0] data;
    logic [9:0] exp_val;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [9:0] ev, rnd_instr, rnd_data;
    logic       ec, ez;

    vecs[0]  = '{10'h000, 10'h155, 10'h155, 1'b0, 1'b0}; // LOAD R0
    vecs[1]  = '{10'h000, 10'h3FF, 10'h3FF, 1'b0, 1'b0}; // LOAD R0
    vecs[2]  = '{10'h004, 10'h001, 10'h001, 1'b0, 1'b0}; // LOAD R1
    vecs[3]  = '{10'h024, 10'h2A5, 10'h000, 1'b1, 1'b1}; // ADD R1,R0 wraps
    vecs[4]  = '{10'h008, 10'h005, 10'h005, 1'b1, 1'b0}; // LOAD R2 (C holds)
    vecs[5]  = '{10'h00C, 10'h007, 10'h007, 1'b1, 1'b0}; // LOAD R3
    vecs[6]  = '{10'h03B, 10'h111, 10'h3FE, 1'b1, 1'b0}; // SUB R2,R3 borrow
    vecs[7]  = '{10'h03A, 10'h000, 10'h000, 1'b0, 1'b1}; // SUB R2,R2
    vecs[8]  = '{10'h013, 10'h3C3, 10'h007, 1'b0, 1'b0}; // COPY R0,R3
    vecs[9]  = '{10'h044, 10'h000, 10'h3F8, 1'b0, 1'b0}; // INV R1,R0
    vecs[10] = '{10'h057, 10'h000, 10'h000, 1'b0, 1'b1}; // AND R1,R3
    vecs[11] = '{10'h064, 10'h000, 10'h007, 1'b0, 1'b0}; // OR R1,R0
    vecs[12] = '{10'h07F, 10'h000, 10'h000, 1'b0, 1'b1}; // XOR R3,R3
    vecs[13] = '{10'h380, 10'h2AA, 10'h2AA, 1'b0, 1'b0}; // LOAD R0, upper bits set
    vecs[14] = '{10'h020, 10'h000, 10'h154, 1'b1, 1'b0}; // ADD R0,R0 doubles

    Reset = 1'b1; STEP = 1'b0; PKb = 1'b0; PEEK_SEL = '0; IN_DATA_BUS = '0;
    step16 = 1'b0; pk16 = 1'b0; sel16 = '0; bus16 = '0;
    idle(2);
    Reset = 1'b0;
    idle(1);
    model_reset();

    // reset state
    chk("rst_tstep", {30'd0, TSTEP}, 0);
    chk("rst_done",  {31'd0, Done}, 0);
    chk("rst_c",     {31'd0, C_FLAG}, 0);
    chk("rst_z",     {31'd0, Z_FLAG}, 0);
    chk("rst_last",  {22'd0, OUT_DATA_BUS}, 0);
    for (int i = 0; i < 4; i++) begin
      PKb = 1'b1; PEEK_SEL = 2'(i); #1;
      chk("rst_reg", {22'd0, OUT_DATA_BUS}, 0);
    end
    PKb = 1'b0;

    // table-driven directed vectors; the model tracks state alongside
    for (int v = 0; v < 15; v++) begin
      model_exec(vecs[v].instr, vecs[v].data, ev, ec, ez);
      run_instr(vecs[v].instr, vecs[v].data, vecs[v].exp_val, vecs[v].exp_c, vecs[v].exp_z);
    end

    // randomized instructions against the model
    for (int r = 0; r < 150; r++) begin
      rnd_instr = 10'($urandom);
      rnd_data  = 10'($urandom);
      if (r % 8 == 0) rnd_data = 10'h000;   // exercise zero results more often
      model_run(rnd_instr, rnd_data);
    end

    // peek during ADD R1,R0 plus a freeze with STEP idle
    model_run(10'h004, 10'h010);
    model_run(10'h000, 10'h001);
    PKb = 1'b1; PEEK_SEL = 2'd1;
    step_bus(10'h024);
    chk("peek_t1_tstep", {30'd0, TSTEP}, 1);
    chk("peek_t1_old",   {22'd0, OUT_DATA_BUS}, 10'h010);
    step_bus(10'($urandom));
    chk("peek_t2_tstep", {30'd0, TSTEP}, 2);
    chk("peek_t2_old",   {22'd0, OUT_DATA_BUS}, 10'h010);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      chk("freeze_tstep", {30'd0, TSTEP}, 2);
      chk("freeze_reg",   {22'd0, OUT_DATA_BUS}, 10'h010);
    end
    step_bus(10'($urandom));
    chk("peek_t3_tstep", {30'd0, TSTEP}, 3);
    chk("peek_t3_old",   {22'd0, OUT_DATA_BUS}, 10'h010);
    step_bus(10'($urandom));
    model_exec(10'h024, 10'h000, ev, ec, ez);
    chk("peek_new",      {22'd0, OUT_DATA_BUS}, {22'd0, ev});
    chk("peek_new_done", {31'd0, Done}, 1);
    PKb = 1'b0;
    idle(1);
    $display("peek ADD R1,R0 -> R1=0x%03h", ev);

    // reset together with STEP at T2 of an ADD
    model_run(10'h000, 10'h3FF);
    model_run(10'h004, 10'h001);
    model_run(10'h024, 10'h000);  // leaves C=1, Z=1
    step_bus(10'h024);
    step_bus(10'($urandom));
    chk("abort_at_t2", {30'd0, TSTEP}, 2);
    STEP = 1'b1; Reset = 1'b1; IN_DATA_BUS = 10'($urandom);
    @(posedge clk); #1;
    STEP = 1'b0; Reset = 1'b0;
    model_reset();
    chk("abort_tstep", {30'd0, TSTEP}, 0);
    chk("abort_done",  {31'd0, Done}, 0);
    chk("abort_c",     {31'd0, C_FLAG}, 0);
    chk("abort_z",     {31'd0, Z_FLAG}, 0);
    chk("abort_last",  {22'd0, OUT_DATA_BUS}, 0);
    for (int i = 0; i < 4; i++) begin
      PKb = 1'b1; PEEK_SEL = 2'(i); #1;
      chk("abort_reg", {22'd0, OUT_DATA_BUS}, 0);
    end
    PKb = 1'b0;
    idle(2);
    chk("abort_no_write_done", {31'd0, Done}, 0);
    $display("reset during ADD T2 -> core cleared");

    // DW=16, NREGS=8 instance
    step16_bus(16'h0038);                      // LOAD R7
    step16_bus(16'hBEEF);
    chk("w16_load_done", {31'd0, done16}, 1);
    chk("w16_load_last", {16'd0, out16}, 16'hBEEF);
    idle(1);
    step16_bus(16'h0137);                      // INV R6,R7
    step16_bus(16'h1234);
    chk("w16_inv_last", {16'd0, out16}, 16'h4110);
    pk16 = 1'b1; sel16 = 3'd6; #1;
    chk("w16_inv_peek", {16'd0, out16}, 16'h4110);
    pk16 = 1'b0;
    idle(1);
    step16 = 1'b1; bus16 = 16'h01FF;           // XOR R7,R7, STEP held high
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("w16_held_tstep", {30'd0, ts16}, k % 4);
    end
    step16 = 1'b0;
    chk("w16_xor_done", {31'd0, done16}, 1);
    chk("w16_xor_z",    {31'd0, z16}, 1);
    chk("w16_xor_last", {16'd0, out16}, 0);
    pk16 = 1'b1; sel16 = 3'd7; #1;
    chk("w16_xor_peek", {16'd0, out16}, 0);
    pk16 = 1'b0;
    idle(1);
    chk("w16_done_clear", {31'd0, done16}, 0);
    $display("wide core: LOAD R7, INV R6, XOR R7 sequence complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
